rotary_encoder_if: RTL

ROTARY_ENCODER_IF -- requirements
Module: rotary_encoder_if

---
 rtl/rotary_pkg.sv | 32 +++
 rtl/rotary_encoder_if_if.sv | 12 +
 rtl/rotary_debounce.sv | 40 ++++
 rtl/rotary_encoder_if.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary encoder peripheral: decoder state encoding,
// read-word bit positions, register address and a saturating adder.
package rotary_pkg;

   typedef enum logic [2:0] {
      ST_REST = 3'd0,
      ST_CW1  = 3'd1,
      ST_CW2  = 3'd2,
      ST_CW3  = 3'd3,
      ST_CCW1 = 3'd4,
      ST_CCW2 = 3'd5,
      ST_CCW3 = 3'd6,
      ST_WAIT = 3'd7
   } rot_state_e;

   localparam logic [11:0] ROT_ADDR     = 12'h818;
   localparam int          ROT_SW_BIT   = 31;
   localparam int          ROT_FLAG_BIT = 30;
   localparam int          ROT_CNT_MSB  = 15;
   localparam int          ROT_CNT_LSB  = 0;

   // Count never wraps: clamp to the 16-bit signed range.
   function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                  input logic signed [4:0]  d);
      logic signed [16:0] s;
      s = 17'(a) + 17'(d);
      if (s > 17'sh0_7FFF)      sat_add = 16'sh7FFF;
      else if (s < -17'sh0_8000) sat_add = 16'sh8000;
      else                       sat_add = s[15:0];
   endfunction

endpackage

// File: rtl/rotary_encoder_if_if.sv
// Pin/bus bundle for the rotary encoder peripheral: raw encoder pins, CPU clear
// strobe and the 32-bit read word.
interface rotary_encoder_if_if;
   logic        enc_a;
   logic        enc_b;
   logic        enc_sw;
   logic        clr;
   logic [31:0] rotary;

   modport master (output enc_a, enc_b, enc_sw, clr, input rotary);
   modport slave  (input enc_a, enc_b, enc_sw, clr, output rotary);
endinterface

// File: rtl/rotary_debounce.sv
// Two-flop synchroniser followed by a stable-count filter; output follows the
// synchronised input only after DEBOUNCE_CYCLES consecutive differing cycles.
module rotary_debounce #(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic INIT            = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt;
   logic          filt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {2{INIT}};
         cnt    <= '0;
         filt   <= INIT;
      end else begin
         sync_q <= {sync_q[0], din};
         // Any return to the filtered level restarts the stability window.
         if (sync_q[1] == filt) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt  <= '0;
            filt <= sync_q[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign dout = filt;

endmodule

// File: rtl/rotary_encoder_if.sv
// Rotary encoder peripheral (read/clear at 0x818): debounced quadrature decode
// into a saturating signed count plus a sticky press flag.
// Optional ROTARY_ACCEL_EN: step 4 for detents closer than FAST_CYCLES apart.
module rotary_encoder_if import rotary_pkg::*; #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int FAST_CYCLES     = 2500000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rotary_encoder_if_if.slave   bus
);

   // Bit order: [2]=A, [1]=B, [0]=switch. Encoder channels idle high.
   localparam logic [2:0] DB_INIT = 3'b110;

   logic [2:0]         raw;
   logic [2:0]         filt;
   logic               a_f, b_f, sw_f;
   logic [1:0]         ab;
   rot_state_e         state, state_nxt;
   logic               step_cw, step_ccw;
   logic signed [4:0]  step;
   logic signed [15:0] count, count_nxt;
   logic               flag, flag_nxt;
   logic               sw_q;
   logic [31:0]        rot;

   assign raw = {bus.enc_a, bus.enc_b, bus.enc_sw};

   for (genvar i = 0; i < 3; i++) begin : g_db
      rotary_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .INIT            (DB_INIT[i])
      ) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .din   (raw[i]),
         .dout  (filt[i])
      );
   end

   assign a_f  = filt[2];
   assign b_f  = filt[1];
   assign sw_f = filt[0];
   assign ab   = {a_f, b_f};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_REST;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      step_cw   = 1'b0;
      step_ccw  = 1'b0;
      unique case (state)
         ST_REST: case (ab)
            2'b01:   state_nxt = ST_CW1;
            2'b10:   state_nxt = ST_CCW1;
            2'b00:   state_nxt = ST_WAIT;
            default: state_nxt = ST_REST;
         endcase
         ST_CW1: case (ab)
            2'b00:   state_nxt = ST_CW2;
            2'b11:   state_nxt = ST_REST;
            2'b10:   state_nxt = ST_WAIT;
            default: state_nxt = ST_CW1;
         endcase
         ST_CW2: case (ab)
            2'b10:   state_nxt = ST_CW3;
            2'b01:   state_nxt = ST_CW1;
            2'b11:   state_nxt = ST_WAIT;
            default: state_nxt = ST_CW2;
         endcase
         ST_CW3: case (ab)
            2'b11: begin
               state_nxt = ST_REST;
               step_cw   = 1'b1;
            end
            2'b00:   state_nxt = ST_CW2;
            2'b01:   state_nxt = ST_WAIT;
            default: state_nxt = ST_CW3;
         endcase
         ST_CCW1: case (ab)
            2'b00:   state_nxt = ST_CCW2;
            2'b11:   state_nxt = ST_REST;
            2'b01:   state_nxt = ST_WAIT;
            default: state_nxt = ST_CCW1;
         endcase
         ST_CCW2: case (ab)
            2'b01:   state_nxt = ST_CCW3;
            2'b10:   state_nxt = ST_CCW1;
            2'b11:   state_nxt = ST_WAIT;
            default: state_nxt = ST_CCW2;
         endcase
         ST_CCW3: case (ab)
            2'b11: begin
               state_nxt = ST_REST;
               step_ccw  = 1'b1;
            end
            2'b00:   state_nxt = ST_CCW2;
            2'b10:   state_nxt = ST_WAIT;
            default: state_nxt = ST_CCW3;
         endcase
         ST_WAIT:    state_nxt = (ab == 2'b11) ? ST_REST : ST_WAIT;
         default:    state_nxt = ST_REST;
      endcase
   end

`ifdef ROTARY_ACCEL_EN
   localparam int IW = $clog2(FAST_CYCLES + 1);
   logic [IW-1:0] ivl;

   // Cycles since the last counted detent, parked at FAST_CYCLES when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    ivl <= IW'(FAST_CYCLES);
      else if (bus.clr)              ivl <= IW'(FAST_CYCLES);
      else if (step_cw || step_ccw)  ivl <= '0;
      else if (ivl < IW'(FAST_CYCLES)) ivl <= ivl + 1'b1;
   end

   assign step = (ivl < IW'(FAST_CYCLES)) ? 5'sd4 : 5'sd1;
`else
   assign step = 5'sd1;
`endif

   always_comb begin
      count_nxt = count;
      flag_nxt  = flag | (sw_f & ~sw_q);
      // Clear wins over a same-cycle step or press edge.
      if (bus.clr) begin
         count_nxt = '0;
         flag_nxt  = 1'b0;
      end else if (step_cw) begin
         count_nxt = sat_add(count, step);
      end else if (step_ccw) begin
         count_nxt = sat_add(count, -step);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         flag  <= 1'b0;
         sw_q  <= 1'b0;
      end else begin
         count <= count_nxt;
         flag  <= flag_nxt;
         sw_q  <= sw_f;
      end
   end

   always_comb begin
      rot                           = '0;
      rot[ROT_SW_BIT]               = sw_f;
      rot[ROT_FLAG_BIT]             = flag;
      rot[ROT_CNT_MSB:ROT_CNT_LSB]  = count;
   end

   assign bus.rotary = rot;

endmodule
